// File: rtl/hazard_sequencer.sv
// ============================================================================
//  Module      : hazard_sequencer
//  Description : Pipeline hazard controller for a 5-stage in-order core.
//                Resolves three hazard classes in priority order:
//                  1. taken branch / jump-register in EX
//                     -> flush IF/ID for two cycles
//                  2. multi-cycle multiply/divide in flight
//                     -> hold ID until MDU_Done or the watchdog fires
//                  3. load-use dependency between EX and ID
//                     -> one-cycle bubble
//                Also keeps saturating stall/flush performance counters and a
//                sticky MDU watchdog timeout flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1  clock, rising-edge active
//    reset           in   1  asynchronous reset, active low
//    ID_rs, ID_rt    in   5  source registers of the ID instruction
//    ID_UsesRt       in   1  ID instruction reads rt
//    EX_MemRead      in   1  EX instruction is a load
//    EX_WriteAddr    in   5  destination register of the EX instruction
//    EX_BranchTaken  in   1  branch/jr resolved taken in EX
//    ID_MduStart     in   1  ID instruction launches a multiply/divide
//    MDU_Done        in   1  multiply/divide result ready (pulse)
//    PC_Write        out  1  PC register enable
//    IF_ID_Write     out  1  IF/ID register enable
//    Stall           out  1  insert bubble into ID/EX (hold)
//    Flush_IF_and_ID out  1  insert bubble into ID/EX (squash)
//    State           out  2  current FSM state
//    Stall_Count     out 16  cycles with Stall=1, saturating
//    Flush_Count     out 16  cycles with Flush_IF_and_ID=1, saturating
//    Mdu_Timeout     out  1  sticky MDU watchdog flag
// ============================================================================
`default_nettype none

module hazard_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteAddr,
  input  logic        EX_BranchTaken,
  input  logic        ID_MduStart,
  input  logic        MDU_Done,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        Stall,
  output logic        Flush_IF_and_ID,
  output logic [1:0]  State,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count,
  output logic        Mdu_Timeout
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  c_ST_RUN      = 2'd0;
  localparam logic [1:0]  c_ST_MDU_WAIT = 2'd1;
  localparam logic [1:0]  c_ST_FLUSH    = 2'd2;

  // The watchdog counts completed wait cycles starting from 0 on entry, so
  // the 63rd consecutive wait cycle is the one in which it reads 62.
  localparam logic [5:0]  c_WD_LAST     = 6'd62;
  localparam logic [15:0] c_CNT_MAX     = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q,     state_d;
  logic [5:0]  wd_q,        wd_d;
  logic        timeout_q,   timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Raw (pre-reset-gating) hazard decisions
  logic w_stall_raw;
  logic w_flush_raw;
  logic w_loaduse;
  logic w_stall;
  logic w_flush;

  // --------------------------------------------------------------------------
  // Load-use detection. Register 0 is hard-wired, so a load into r0 never
  // creates a dependency.
  // --------------------------------------------------------------------------
  assign w_loaduse = EX_MemRead
                   & (EX_WriteAddr != 5'd0)
                   & ((EX_WriteAddr == ID_rs)
                      | (ID_UsesRt & (EX_WriteAddr == ID_rt)));

  // --------------------------------------------------------------------------
  // Next-state and hazard decision
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    w_stall_raw = 1'b0;
    w_flush_raw = 1'b0;

    if (EX_BranchTaken) begin
      // A taken branch overrides everything, including an MDU wait: the
      // instruction waiting in ID is on the wrong path anyway.
      w_flush_raw = 1'b1;
      state_d     = c_ST_FLUSH;
      wd_d        = 6'd0;
    end else begin
      case (state_q)
        c_ST_RUN: begin
          if (w_loaduse) begin
            w_stall_raw = 1'b1;
          end else if (ID_MduStart) begin
            // The MDU instruction itself proceeds; the hold applies to
            // whatever follows it.
            state_d = c_ST_MDU_WAIT;
            wd_d    = 6'd0;
          end
        end

        c_ST_MDU_WAIT: begin
          if (MDU_Done) begin
            state_d = c_ST_RUN;
            wd_d    = 6'd0;
          end else begin
            w_stall_raw = 1'b1;
            if (wd_q == c_WD_LAST) begin
              timeout_d = 1'b1;
              state_d   = c_ST_RUN;
              wd_d      = 6'd0;
            end else begin
              wd_d = wd_q + 6'd1;
            end
          end
        end

        c_ST_FLUSH: begin
          // Second flush cycle squashes the instruction fetched behind the
          // branch. Load-use is ignored here: that instruction is discarded.
          w_flush_raw = 1'b1;
          state_d     = c_ST_RUN;
        end

        default: begin
          // Unreachable encoding: behave as a hazard-free RUN and recover.
          state_d = c_ST_RUN;
          wd_d    = 6'd0;
        end
      endcase
    end
  end

  // While reset is held the control outputs take their RUN defaults
  // regardless of the hazard inputs.
  assign w_stall = reset & w_stall_raw;
  assign w_flush = reset & w_flush_raw;

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall && (stall_cnt_q != c_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (w_flush && (flush_cnt_q != c_CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= c_ST_RUN;
      wd_q        <= 6'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Stall           = w_stall;
  assign Flush_IF_and_ID = w_flush;
  assign PC_Write        = ~w_stall;
  assign IF_ID_Write     = ~w_stall;
  assign State           = state_q;
  assign Stall_Count     = stall_cnt_q;
  assign Flush_Count     = flush_cnt_q;
  assign Mdu_Timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
// ============================================================================
//  Module      : tb_hazard_sequencer
//  Description : Directed self-checking bench for hazard_sequencer. Expected
//                per-cycle control outputs are queued when inputs are driven
//                and compared when the cycle's outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_sequencer;

  logic        clk;
  logic        reset;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UsesRt;
  logic        EX_MemRead;
  logic [4:0]  EX_WriteAddr;
  logic        EX_BranchTaken;
  logic        ID_MduStart;
  logic        MDU_Done;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        Stall;
  logic        Flush_IF_and_ID;
  logic [1:0]  State;
  logic [15:0] Stall_Count;
  logic [15:0] Flush_Count;
  logic        Mdu_Timeout;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] MDUW = 2'd1;
  localparam logic [1:0] FLSH = 2'd2;

  // Expected {State, Stall, Flush, PC_Write, IF_ID_Write}
  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;
  exp_t sb[$];

  hazard_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .ID_rs           (ID_rs),
    .ID_rt           (ID_rt),
    .ID_UsesRt       (ID_UsesRt),
    .EX_MemRead      (EX_MemRead),
    .EX_WriteAddr    (EX_WriteAddr),
    .EX_BranchTaken  (EX_BranchTaken),
    .ID_MduStart     (ID_MduStart),
    .MDU_Done        (MDU_Done),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .Stall           (Stall),
    .Flush_IF_and_ID (Flush_IF_and_ID),
    .State           (State),
    .Stall_Count     (Stall_Count),
    .Flush_Count     (Flush_Count),
    .Mdu_Timeout     (Mdu_Timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout observed=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic set_in(input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic br,
                        input logic ms, input logic dn);
    EX_MemRead = mr; EX_WriteAddr = wa; ID_rs = rs; ID_rt = rt;
    ID_UsesRt = ur; EX_BranchTaken = br; ID_MduStart = ms; MDU_Done = dn;
  endtask

  task automatic compare_ctl(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {State, Stall, Flush_IF_and_ID, PC_Write, IF_ID_Write};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={st,stall,flush,pcw,ifw}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set; enter at posedge+1, leave at
  // the next posedge+1.
  task automatic cyc(input string tag, input logic [1:0] st, input logic stl, input logic fl);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.exp = {st, stl, fl, ~stl, ~stl};
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    compare_ctl(got.tag, got.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset, with a load-use pattern on the inputs ----------
    reset = 1'b0;
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    compare_ctl("reset_outputs", {RUN, 1'b0, 1'b0, 1'b1, 1'b1});
    chk16("reset_stall_cnt", Stall_Count, 16'd0);
    chk16("reset_flush_cnt", Flush_Count, 16'd0);
    chk1("reset_timeout", Mdu_Timeout, 1'b0);
    @(posedge clk); #1;
    compare_ctl("reset_held_edge", {RUN, 1'b0, 1'b0, 1'b1, 1'b1});
    reset = 1'b1;

    // ---------------- load-use on rs ----------------
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs_stall", RUN, 1'b1, 1'b0);
    set_in(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs_release", RUN, 1'b0, 1'b0);
    chk16("lu_rs_cnt", Stall_Count, 16'd1);

    // ---------------- load-use on rt: only when ID_UsesRt ----------------
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt_stall", RUN, 1'b1, 1'b0);
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt_unused", RUN, 1'b0, 1'b0);

    // ---------------- load into r0 never stalls ----------------
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_r0", RUN, 1'b0, 1'b0);
    // no load -> no stall
    set_in(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("no_load", RUN, 1'b0, 1'b0);
    chk16("lu_total_cnt", Stall_Count, 16'd2);

    // ---------------- MDU with done after 10 wait cycles ----------------
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mdu_start", RUN, 1'b0, 1'b0);
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc($sformatf("mdu_wait%0d", i), MDUW, 1'b1, 1'b0);
    MDU_Done = 1'b1;
    cyc("mdu_done", MDUW, 1'b0, 1'b0);
    MDU_Done = 1'b0;
    cyc("mdu_back_run", RUN, 1'b0, 1'b0);
    chk16("mdu_stall_cnt", Stall_Count, 16'd12);

    // ---------------- branch together with load-use ----------------
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("br_flush1", RUN, 1'b0, 1'b1);
    EX_BranchTaken = 1'b0;
    cyc("br_flush2", FLSH, 1'b0, 1'b1);
    EX_MemRead = 1'b0;
    cyc("br_after", RUN, 1'b0, 1'b0);
    chk16("br_flush_cnt", Flush_Count, 16'd2);
    chk16("br_stall_cnt", Stall_Count, 16'd12);

    // ---------------- branch abandons an MDU wait ----------------
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mdu2_start", RUN, 1'b0, 1'b0);
    ID_MduStart = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("mdu2_wait%0d", i), MDUW, 1'b1, 1'b0);
    EX_BranchTaken = 1'b1;
    cyc("mdu2_branch", MDUW, 1'b0, 1'b1);
    EX_BranchTaken = 1'b0;
    cyc("mdu2_flush", FLSH, 1'b0, 1'b1);
    cyc("mdu2_run", RUN, 1'b0, 1'b0);
    chk16("mdu2_stall_cnt", Stall_Count, 16'd15);
    chk16("mdu2_flush_cnt", Flush_Count, 16'd4);

    // ---------------- watchdog: MDU_Done never comes ----------------
    ID_MduStart = 1'b1;
    cyc("wd_start", RUN, 1'b0, 1'b0);
    ID_MduStart = 1'b0;
    for (int i = 0; i < 62; i++) cyc($sformatf("wd_wait%0d", i), MDUW, 1'b1, 1'b0);
    chk1("wd_not_yet", Mdu_Timeout, 1'b0);
    cyc("wd_wait62", MDUW, 1'b1, 1'b0);
    chk1("wd_fired", Mdu_Timeout, 1'b1);
    cyc("wd_run", RUN, 1'b0, 1'b0);
    cyc("wd_run2", RUN, 1'b0, 1'b0);
    chk1("wd_sticky", Mdu_Timeout, 1'b1);
    chk16("wd_stall_cnt", Stall_Count, 16'd78);

    // ---------------- stall counter saturation ----------------
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    chk16("stall_saturated", Stall_Count, 16'hFFFF);
    cyc("sat_still_stall", RUN, 1'b1, 1'b0);
    chk16("stall_no_wrap", Stall_Count, 16'hFFFF);
    chk1("sat_timeout_held", Mdu_Timeout, 1'b1);

    // ---------------- asynchronous reset in the middle of MDU_WAIT ----------
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rst_mdu_start", RUN, 1'b0, 1'b0);
    ID_MduStart = 1'b0;
    cyc("rst_mdu_wait", MDUW, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    compare_ctl("async_reset_ctl", {RUN, 1'b0, 1'b0, 1'b1, 1'b1});
    chk16("async_reset_stall_cnt", Stall_Count, 16'd0);
    chk16("async_reset_flush_cnt", Flush_Count, 16'd0);
    chk1("async_reset_timeout", Mdu_Timeout, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc("post_reset_run", RUN, 1'b0, 1'b0);
    cyc("post_reset_run2", RUN, 1'b0, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports ID_rs and ID_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-004 SHALL have port ID_UsesRt, input, 1 bit: the ID instruction reads rt.
REQ-005 SHALL have ports EX_MemRead (input, 1 bit) and EX_WriteAddr (input, 5 bits): the EX instruction is a load and names its destination register.
REQ-006 SHALL have port EX_BranchTaken, input, 1 bit: a branch or jump-register resolved as taken in EX.
REQ-007 SHALL have port ID_MduStart, input, 1 bit: the ID instruction launches a multi-cycle multiply/divide.
REQ-008 SHALL have port MDU_Done, input, 1 bit: multiply/divide result ready (one-cycle pulse).
REQ-009 SHALL have ports PC_Write and IF_ID_Write, output, 1 bit each: enables for the PC and IF/ID registers.
REQ-010 SHALL have ports Stall and Flush_IF_and_ID, output, 1 bit each: bubble-insert controls for the ID/EX register.
REQ-011 SHALL have port State, output, 2 bits: current FSM state.
REQ-012 SHALL have ports Stall_Count and Flush_Count, output, 16 bits each: performance counters.
REQ-013 SHALL have port Mdu_Timeout, output, 1 bit: sticky watchdog flag.

Function
REQ-014 SHALL implement FSM states RUN=2'd0, MDU_WAIT=2'd1, FLUSH=2'd2; 2'd3 is illegal and SHALL return to RUN on the next edge with all outputs as in RUN.
REQ-015 SHALL define loaduse = EX_MemRead & (EX_WriteAddr!=0) & ((EX_WriteAddr==ID_rs) | (ID_UsesRt & (EX_WriteAddr==ID_rt))), combinationally.
REQ-016 SHALL apply priority, highest first: EX_BranchTaken, MDU_WAIT hold, loaduse, ID_MduStart.
REQ-017 SHALL, when EX_BranchTaken=1 in any state, drive Flush_IF_and_ID=1, Stall=0, PC_Write=1, IF_ID_Write=1 in the same cycle and enter FLUSH; an MDU wait in progress is abandoned and the watchdog cleared.
REQ-018 SHALL, in FLUSH with EX_BranchTaken=0, drive Flush_IF_and_ID=1 for exactly that one cycle, then enter RUN (two-cycle branch penalty total).
REQ-019 SHALL, in RUN with loaduse=1 and no branch, drive Stall=1, PC_Write=0, IF_ID_Write=0 for that cycle only; State stays RUN.
REQ-020 SHALL, in RUN with ID_MduStart=1, loaduse=0 and no branch, pass the instruction (no stall that cycle) and enter MDU_WAIT.
REQ-021 SHALL, in MDU_WAIT with MDU_Done=0, drive Stall=1, PC_Write=0, IF_ID_Write=0; with MDU_Done=1, drive no stall and enter RUN in the same cycle's edge.
REQ-022 SHALL run a 6-bit watchdog in MDU_WAIT, cleared on entry; at 63 cycles without MDU_Done it SHALL set Mdu_Timeout=1 and enter RUN; Mdu_Timeout is cleared only by reset.
REQ-023 SHALL, in RUN with no hazard, drive PC_Write=1, IF_ID_Write=1, Stall=0, Flush_IF_and_ID=0.
REQ-024 SHALL increment Stall_Count every cycle Stall=1 and Flush_Count every cycle Flush_IF_and_ID=1, each saturating at 16'hFFFF (no wrap).
REQ-025 SHALL never assert Stall and Flush_IF_and_ID in the same cycle.

Reset
REQ-026 SHALL, while reset=0, force State=RUN, counters=0, watchdog=0, Mdu_Timeout=0, Stall=0, Flush_IF_and_ID=0, PC_Write=1, IF_ID_Write=1, independent of clk.
REQ-027 SHALL, on reset asserted mid-MDU_WAIT or mid-FLUSH, abandon the operation immediately; the first post-reset cycle is RUN.

Verification
REQ-028 SHALL cover: EX_MemRead=1, EX_WriteAddr=5, ID_rs=5 -> one cycle Stall=1, PC_Write=0; next cycle (EX_MemRead=0) Stall=0; Stall_Count=1.
REQ-029 SHALL cover: EX_MemRead=1, EX_WriteAddr=0, ID_rs=0 -> no stall.
REQ-030 SHALL cover: ID_MduStart pulse, MDU_Done after 10 cycles -> Stall=1 for 10 cycles, State 1 then 0, Stall_Count=10.
REQ-031 SHALL cover: EX_BranchTaken pulse together with loaduse=1 -> Flush_IF_and_ID=1 for 2 cycles, Stall=0 throughout, Flush_Count=2.
REQ-032 SHALL cover: ID_MduStart with MDU_Done never asserted -> Mdu_Timeout=1 after 63 wait cycles, State=RUN, flag held until reset=0.
REQ-033 SHALL cover: Stall_Count preloaded near saturation by 65540 load-use cycles -> reads 16'hFFFF; reset=0 mid-MDU_WAIT -> State=0 asynchronously.
